// File: rtl/miner_pkg.sv
// Shared types and widths for the miner datapath and scheduling logic.
package miner_pkg;

  localparam int MID_W     = 256;
  localparam int HEAD_W    = 512;
  localparam int NONCE_W   = 32;
  localparam int SOL_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_REPORT = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after the pointer,
// wrapping. The pointer register lives in the caller.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx,
  output logic          o_valid
);

  logic [PW-1:0] w_j;

  // Scan N positions starting at the pointer; keep the first hit only.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_j     = '0;
    for (int k = 0; k < N; k++) begin
      w_j = PW'((int'(i_ptr) + k) % N);
      if (!o_valid && i_req[w_j]) begin
        o_valid      = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx        = w_j;
      end
    end
  end

endmodule

// File: rtl/core_scheduler.sv
// Work dispatcher and solution arbiter for a bank of hashing cores.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for a work unit; work_ready high
// ST_LOAD   | work latched, core_start pulsing this cycle
// ST_RUN    | cores hashing; grant found bits, watch for full completion
// ST_REPORT | one solution on sol_valid/sol_nonce, waiting for sol_ready
module core_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int NONCE_W   = miner_pkg::NONCE_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           work_valid,
  output logic                           work_ready,
  input  logic [miner_pkg::MID_W-1:0]    work_mid,
  input  logic [miner_pkg::HEAD_W-1:0]   work_head,
  input  logic                           abort,
  output logic [miner_pkg::MID_W-1:0]    core_mid,
  output logic [miner_pkg::HEAD_W-1:0]   core_head,
  output logic                           core_start,
  output logic                           core_abort,
  output logic [NUM_CORES*NONCE_W-1:0]   core_nonce_base,
  input  logic [NUM_CORES-1:0]           core_found,
  input  logic [NUM_CORES*NONCE_W-1:0]   core_nonce,
  input  logic [NUM_CORES-1:0]           core_done,
  output logic [NUM_CORES-1:0]           core_ack,
  output logic                           sol_valid,
  output logic [NONCE_W-1:0]             sol_nonce,
  input  logic                           sol_ready,
  output logic                           exhausted,
  output logic                           busy,
  output logic [miner_pkg::SOL_CNT_W-1:0] sol_count
);

  import miner_pkg::*;

  localparam int PW    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int SHIFT = NONCE_W - $clog2(NUM_CORES);

  sched_state_t r_state, w_state_nxt;

  logic [PW-1:0]        r_rr_ptr;
  logic [NUM_CORES-1:0] r_done_mask;
  logic [NONCE_W-1:0]   w_nonce_arr [NUM_CORES];

  logic [NUM_CORES-1:0] w_grant;
  logic [PW-1:0]        w_idx;
  logic                 w_req_any;
  logic                 w_done_all;

  logic w_accept;
  logic w_grant_take;
  logic w_sol_take;
  logic w_abort_take;
  logic w_exhaust;

  // Each core owns an equal, fixed slice of the nonce space.
  for (genvar i = 0; i < NUM_CORES; i++) begin : g_slice
    assign core_nonce_base[i*NONCE_W +: NONCE_W] = NONCE_W'(i) << SHIFT;
    assign w_nonce_arr[i] = core_nonce[i*NONCE_W +: NONCE_W];
  end

  rr_arbiter #(.N(NUM_CORES), .PW(PW)) u_arb (
    .i_req   (core_found),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_req_any)
  );

  // Completion includes this cycle's done pulses so the last one is not late.
  assign w_done_all = &(r_done_mask | core_done);

  assign work_ready = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and control strobes; abort outranks everything once busy,
  // and a found bit outranks completion so no solution is dropped.
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_grant_take = 1'b0;
    w_sol_take   = 1'b0;
    w_abort_take = 1'b0;
    w_exhaust    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (work_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          w_abort_take = 1'b1;
          w_state_nxt  = ST_IDLE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          w_abort_take = 1'b1;
          w_state_nxt  = ST_IDLE;
        end else if (w_req_any) begin
          w_grant_take = 1'b1;
          w_state_nxt  = ST_REPORT;
        end else if (w_done_all) begin
          w_exhaust   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REPORT: begin
        if (abort) begin
          w_abort_take = 1'b1;
          w_state_nxt  = ST_IDLE;
        end else if (sol_valid && sol_ready) begin
          w_sol_take  = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs and bookkeeping driven by the strobes above.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_mid    <= '0;
      core_head   <= '0;
      core_start  <= 1'b0;
      core_abort  <= 1'b0;
      core_ack    <= '0;
      sol_valid   <= 1'b0;
      sol_nonce   <= '0;
      exhausted   <= 1'b0;
      sol_count   <= '0;
      r_rr_ptr    <= '0;
      r_done_mask <= '0;
    end else begin
      core_start <= w_accept;
      core_abort <= w_abort_take;
      exhausted  <= w_exhaust;
      core_ack   <= w_grant_take ? w_grant : '0;

      if (w_accept) begin
        core_mid  <= work_mid;
        core_head <= work_head;
      end

      if (w_accept || w_abort_take)
        r_done_mask <= '0;
      else if (r_state == ST_RUN || r_state == ST_REPORT)
        r_done_mask <= r_done_mask | core_done;

      if (w_grant_take) begin
        sol_valid <= 1'b1;
        sol_nonce <= w_nonce_arr[w_idx];
        r_rr_ptr  <= (w_idx == PW'(NUM_CORES - 1)) ? '0 : w_idx + PW'(1);
      end else if (w_sol_take || w_abort_take) begin
        sol_valid <= 1'b0;
      end

      if (w_accept)
        sol_count <= '0;
      else if (w_sol_take && (sol_count != '1))
        sol_count <= sol_count + SOL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_core_scheduler.sv
// Directed bench for core_scheduler with a nonce scoreboard.
module tb_core_scheduler;

  localparam int NC = 4;
  localparam int NW = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              work_valid;
  logic              work_ready;
  logic [255:0]      work_mid;
  logic [511:0]      work_head;
  logic              abort;
  logic [255:0]      core_mid;
  logic [511:0]      core_head;
  logic              core_start;
  logic              core_abort;
  logic [NC*NW-1:0]  core_nonce_base;
  logic [NC-1:0]     core_found;
  logic [NC*NW-1:0]  core_nonce;
  logic [NC-1:0]     core_done;
  logic [NC-1:0]     core_ack;
  logic              sol_valid;
  logic [NW-1:0]     sol_nonce;
  logic              sol_ready;
  logic              exhausted;
  logic              busy;
  logic [15:0]       sol_count;

  int n_cmp = 0;
  int n_err = 0;
  int start_cnt = 0;
  int exh_cnt = 0;
  int ack_cnt = 0;
  logic [31:0] sb_q[$];

  core_scheduler #(.NUM_CORES(NC), .NONCE_W(NW)) dut (
    .clk(clk), .reset(reset),
    .work_valid(work_valid), .work_ready(work_ready),
    .work_mid(work_mid), .work_head(work_head), .abort(abort),
    .core_mid(core_mid), .core_head(core_head),
    .core_start(core_start), .core_abort(core_abort),
    .core_nonce_base(core_nonce_base),
    .core_found(core_found), .core_nonce(core_nonce),
    .core_done(core_done), .core_ack(core_ack),
    .sol_valid(sol_valid), .sol_nonce(sol_nonce), .sol_ready(sol_ready),
    .exhausted(exhausted), .busy(busy), .sol_count(sol_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer and event counters, sampled mid-cycle.
  always @(negedge clk) begin
    logic [31:0] exp_n;
    if (reset === 1'b0) begin
      if (core_start === 1'b1) start_cnt++;
      if (exhausted === 1'b1) exh_cnt++;
      if (core_ack !== '0) ack_cnt++;
      if (sol_valid === 1'b1 && sol_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_solution", 64'(sb_q.size()), 64'd1);
        end else begin
          exp_n = sb_q.pop_front();
          chk("sb_nonce", 64'(sol_nonce), 64'(exp_n));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nonce(input int idx, input logic [31:0] val);
    core_nonce[idx*NW +: NW] = val;
  endtask

  // Grant must appear on the very next edge.
  task automatic wait_ack(input int idx, input logic [31:0] nonce);
    logic [NC-1:0] exp_ack;
    exp_ack = '0;
    exp_ack[idx] = 1'b1;
    step();
    chk("core_ack", 64'(core_ack), 64'(exp_ack));
    chk("sol_valid_on_grant", 64'(sol_valid), 64'd1);
    chk("sol_nonce_on_grant", 64'(sol_nonce), 64'(nonce));
    core_found[idx] = 1'b0;
  endtask

  task automatic wait_drop();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (sol_valid === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    chk("sol_valid_drop_timeout", 64'(seen), 64'd1);
  endtask

  initial begin
    logic [255:0] mid_a;
    logic [511:0] head_a;
    mid_a  = {8{32'h1234_5678}};
    head_a = {16{32'hCAFE_F00D}};

    reset = 1'b1; work_valid = 1'b0; work_mid = '0; work_head = '0; abort = 1'b0;
    core_found = '0; core_nonce = '0; core_done = '0; sol_ready = 1'b0;
    repeat (3) step();
    chk("rst_work_ready", 64'(work_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_core_start", 64'(core_start), 64'd0);
    chk("rst_sol_valid", 64'(sol_valid), 64'd0);
    chk("rst_core_ack", 64'(core_ack), 64'd0);
    chk("rst_sol_count", 64'(sol_count), 64'd0);
    reset = 1'b0;
    step();

    // Work unit accept and start pulse.
    work_valid = 1'b1; work_mid = mid_a; work_head = head_a;
    step();
    work_valid = 1'b0;
    chk("load_core_start", 64'(core_start), 64'd1);
    chk("load_busy", 64'(busy), 64'd1);
    chk("load_work_ready", 64'(work_ready), 64'd0);
    chk("load_core_mid", 64'(core_mid === mid_a), 64'd1);
    chk("load_core_head", 64'(core_head === head_a), 64'd1);
    chk("base0", 64'(core_nonce_base[0*NW +: NW]), 64'h0000_0000);
    chk("base1", 64'(core_nonce_base[1*NW +: NW]), 64'h4000_0000);
    chk("base2", 64'(core_nonce_base[2*NW +: NW]), 64'h8000_0000);
    chk("base3", 64'(core_nonce_base[3*NW +: NW]), 64'hC000_0000);
    step();
    chk("run_core_start_low", 64'(core_start), 64'd0);
    chk("run_busy", 64'(busy), 64'd1);

    // Single solution from core 2.
    sol_ready = 1'b1;
    set_nonce(2, 32'h8000_1234); core_found = 4'b0100; sb_q.push_back(32'h8000_1234);
    wait_ack(2, 32'h8000_1234);
    wait_drop();
    chk("sol_count_1", 64'(sol_count), 64'd1);

    // Core 0 alone moves the pointer to 1.
    set_nonce(0, 32'h0000_0077); core_found = 4'b0001; sb_q.push_back(32'h0000_0077);
    wait_ack(0, 32'h0000_0077);
    wait_drop();
    chk("sol_count_2", 64'(sol_count), 64'd2);

    // Fairness: cores 0 and 3 together with pointer at 1 -> 3 then 0.
    set_nonce(0, 32'h0000_0100); set_nonce(3, 32'hC000_0300); core_found = 4'b1001;
    sb_q.push_back(32'hC000_0300); sb_q.push_back(32'h0000_0100);
    wait_ack(3, 32'hC000_0300);
    wait_drop();
    wait_ack(0, 32'h0000_0100);
    wait_drop();
    chk("sol_count_4", 64'(sol_count), 64'd4);

    // Pointer is back at 1: cores 0 and 1 together -> 1 first.
    set_nonce(0, 32'h0000_0002); set_nonce(1, 32'h4000_0001); core_found = 4'b0011;
    sb_q.push_back(32'h4000_0001); sb_q.push_back(32'h0000_0002);
    wait_ack(1, 32'h4000_0001);
    wait_drop();
    wait_ack(0, 32'h0000_0002);
    wait_drop();
    chk("sol_count_6", 64'(sol_count), 64'd6);

    // Backpressure with done pulses from cores 0 and 3 while waiting.
    sol_ready = 1'b0;
    set_nonce(1, 32'h4000_AAAA); set_nonce(2, 32'h8000_BBBB); core_found = 4'b0110;
    sb_q.push_back(32'h4000_AAAA); sb_q.push_back(32'h8000_BBBB);
    wait_ack(1, 32'h4000_AAAA);
    for (int k = 0; k < 10; k++) begin
      core_done = (k == 2) ? 4'b0001 : (k == 5) ? 4'b1000 : 4'b0000;
      step();
      chk("bp_sol_valid", 64'(sol_valid), 64'd1);
      chk("bp_sol_nonce", 64'(sol_nonce), 64'h4000_AAAA);
      chk("bp_no_ack", 64'(core_ack), 64'd0);
    end
    core_done = '0;
    sol_ready = 1'b1;
    wait_drop();
    wait_ack(2, 32'h8000_BBBB);
    wait_drop();
    chk("sol_count_8", 64'(sol_count), 64'd8);

    // Exhaustion: last done coincides with a found; solution goes first.
    sol_ready = 1'b0;
    core_done = 4'b0100;
    step();
    core_done = '0;
    chk("exh_early", 64'(exhausted), 64'd0);
    set_nonce(1, 32'h4000_CCCC); core_found = 4'b0010; core_done = 4'b0010;
    sb_q.push_back(32'h4000_CCCC);
    wait_ack(1, 32'h4000_CCCC);
    core_done = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("exh_hold_off", 64'(exhausted), 64'd0);
      chk("exh_sol_pending", 64'(sol_valid), 64'd1);
    end
    sol_ready = 1'b1;
    wait_drop();
    chk("exh_not_at_drop", 64'(exhausted), 64'd0);
    step();
    chk("exh_pulse", 64'(exhausted), 64'd1);
    chk("exh_work_ready", 64'(work_ready), 64'd1);
    chk("exh_busy", 64'(busy), 64'd0);
    step();
    chk("exh_one_cycle", 64'(exhausted), 64'd0);
    chk("sol_count_9", 64'(sol_count), 64'd9);
    sol_ready = 1'b0;

    // Abort while a solution waits in REPORT.
    work_valid = 1'b1; work_mid = ~mid_a; work_head = ~head_a;
    step();
    work_valid = 1'b0;
    chk("w2_core_start", 64'(core_start), 64'd1);
    chk("w2_sol_count", 64'(sol_count), 64'd0);
    step();
    set_nonce(3, 32'hC000_0001); core_found = 4'b1000;
    wait_ack(3, 32'hC000_0001);
    step();
    chk("abort_pre_valid", 64'(sol_valid), 64'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_core_abort", 64'(core_abort), 64'd1);
    chk("abort_sol_valid", 64'(sol_valid), 64'd0);
    chk("abort_work_ready", 64'(work_ready), 64'd1);
    chk("abort_core_ack", 64'(core_ack), 64'd0);
    step();
    chk("abort_one_cycle", 64'(core_abort), 64'd0);

    // Fresh work after abort: completion needs all four cores again.
    work_valid = 1'b1;
    step();
    work_valid = 1'b0;
    chk("w3_core_start", 64'(core_start), 64'd1);
    chk("w3_sol_count", 64'(sol_count), 64'd0);
    step();
    for (int k = 0; k < 3; k++) begin
      core_done = '0;
      core_done[k] = 1'b1;
      step();
      core_done = '0;
      chk("w3_no_exh", 64'(exhausted), 64'd0);
      chk("w3_busy", 64'(busy), 64'd1);
    end
    repeat (2) begin
      step();
      chk("w3_no_exh_idle", 64'(exhausted), 64'd0);
    end
    core_done = 4'b1000;
    step();
    core_done = '0;
    chk("w3_exh", 64'(exhausted), 64'd1);
    chk("w3_work_ready", 64'(work_ready), 64'd1);
    step();

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    chk("ack_total", 64'(ack_cnt), 64'd10);
    chk("start_total", 64'(start_cnt), 64'd3);
    chk("exh_total", 64'(exh_cnt), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
